// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - phase type and default 640x480@60 timing constants for vga_timing_gen
package vga_timing_pkg;

    typedef enum logic [1:0] {
        PH_VIS  = 2'd0,
        PH_FP   = 2'd1,
        PH_SYNC = 2'd2,
        PH_BP   = 2'd3
    } phase_t;

    localparam int CNT_W = 10;

    localparam int H_VIS_DEF  = 640;
    localparam int H_FP_DEF   = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;
    localparam int H_TOTAL    = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_VIS_DEF  = 480;
    localparam int V_FP_DEF   = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;
    localparam int V_TOTAL    = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

endpackage

// File: rtl/vga_axis_gen.sv
// rtl/vga_axis_gen.sv - one raster axis: phase FSM, position counter, sync level and wrap strobe
module vga_axis_gen
    import vga_timing_pkg::*;
#(
    parameter int VIS      = H_VIS_DEF,
    parameter int FP       = H_FP_DEF,
    parameter int SYNC     = H_SYNC_DEF,
    parameter int BP       = H_BP_DEF,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output logic             sync,
    output logic             active_nxt,
    output logic             wrap
);

    localparam int TOTAL = VIS + FP + SYNC + BP;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    phase_t           phase, phase_nxt;
    logic [CNT_W-1:0] pcnt, pcnt_nxt, count_nxt, plast;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            phase <= PH_BP;
            pcnt  <= CNT_W'(BP - 1);
            count <= LAST;
            sync  <= ~SYNC_POL;
        end else begin
            phase <= phase_nxt;
            pcnt  <= pcnt_nxt;
            count <= count_nxt;
            sync  <= (phase_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        end
    end

    always_comb begin
        plast = '0;
        case (phase)
            PH_VIS:  plast = CNT_W'(VIS - 1);
            PH_FP:   plast = CNT_W'(FP - 1);
            PH_SYNC: plast = CNT_W'(SYNC - 1);
            PH_BP:   plast = CNT_W'(BP - 1);
            default: plast = '0;
        endcase
    end

    // The end of the back porch is the only place the axis position wraps.
    always_comb begin
        phase_nxt = phase;
        pcnt_nxt  = pcnt;
        count_nxt = count;
        wrap      = 1'b0;
        if (step) begin
            if (pcnt > plast || count > LAST) begin
                phase_nxt = PH_BP;
                pcnt_nxt  = CNT_W'(BP - 1);
                count_nxt = LAST;
            end else if (pcnt == plast) begin
                pcnt_nxt = '0;
                case (phase)
                    PH_VIS:  phase_nxt = PH_FP;
                    PH_FP:   phase_nxt = PH_SYNC;
                    PH_SYNC: phase_nxt = PH_BP;
                    default: phase_nxt = PH_VIS;
                endcase
                if (phase == PH_BP) begin
                    count_nxt = '0;
                    wrap      = 1'b1;
                end else begin
                    count_nxt = count + CNT_W'(1);
                end
            end else begin
                pcnt_nxt  = pcnt + CNT_W'(1);
                count_nxt = count + CNT_W'(1);
            end
        end
    end

    assign active_nxt = (phase_nxt == PH_VIS);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator; VGA_FRAMECNT_EN adds the frame_cnt output
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VIS    = H_VIS_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_VIS    = V_VIS_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = 1'b0,
    parameter int FRAME_W  = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pix_en,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_FRAMECNT_EN
    ,
    output logic [FRAME_W-1:0] frame_cnt
`endif
);

    logic h_act_nxt, v_act_nxt, h_wrap, v_wrap;

    vga_axis_gen #(
        .VIS(H_VIS), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SYNC_POL(SYNC_POL)
    ) u_h_axis (
        .clk(clk), .clr(clr), .step(pix_en),
        .count(hcount), .sync(hsync), .active_nxt(h_act_nxt), .wrap(h_wrap)
    );

    // The vertical axis steps only on the pixel that ends a line.
    vga_axis_gen #(
        .VIS(V_VIS), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SYNC_POL(SYNC_POL)
    ) u_v_axis (
        .clk(clk), .clr(clr), .step(h_wrap),
        .count(vcount), .sync(vsync), .active_nxt(v_act_nxt), .wrap(v_wrap)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            video_on    <= h_act_nxt & v_act_nxt;
            line_start  <= h_wrap;
            frame_start <= v_wrap;
        end
    end

`ifdef VGA_FRAMECNT_EN
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            frame_cnt <= '0;
        end else if (v_wrap) begin
            frame_cnt <= frame_cnt + FRAME_W'(1);
        end
    end
`endif

endmodule
